// File: rtl/netdma_mm_ram_slave.sv
// Dual-port on-chip RAM slave that terminates the netdma Avalon-MM read and write masters.
// The read port returns pipelined readdatavalid; optional LFSR-driven waitrequest injection.
module netdma_mm_ram_slave #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_PENDING  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_en,
  input  logic [31:0]           rd_address,
  input  logic                  rd_read,
  output logic [DATA_WIDTH-1:0] rd_readdata,
  output logic                  rd_readdatavalid,
  output logic                  rd_waitrequest,
  input  logic [31:0]           wr_address,
  input  logic                  wr_write,
  input  logic [DATA_WIDTH-1:0] wr_writedata,
  output logic                  wr_waitrequest,
  output logic [15:0]           err_cnt
);

  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int unsigned BYTE_BITS      = $clog2(BYTES_PER_WORD);
  localparam int unsigned IDX_W          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES     = 33'(DEPTH_WORDS * BYTES_PER_WORD);
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;
  localparam logic [3:0]  PEND_LIMIT     = 4'(MAX_PENDING);

  logic [15:0]           lfsr;
  logic                  lfsr_fb;
  logic                  stall_rd;
  logic                  stall_wr;
  logic [3:0]            pending_cnt;
  logic [32:0]           rd_off;
  logic [32:0]           wr_off;
  logic                  rd_in_range;
  logic                  wr_in_range;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  rd_retire;
  logic [1:0]            err_inc;
  logic [16:0]           err_sum;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [READ_LATENCY-1:0] err_pipe;
  logic [DATA_WIDTH-1:0] dat_pipe [READ_LATENCY];
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Address decode: an address below BASE_ADDR wraps negative and sets the borrow bit.
  always_comb begin
    rd_off      = 33'(rd_address) - 33'(BASE_ADDR);
    wr_off      = 33'(wr_address) - 33'(BASE_ADDR);
    rd_in_range = !rd_off[32] && (rd_off < SPAN_BYTES);
    wr_in_range = !wr_off[32] && (wr_off < SPAN_BYTES);
    rd_idx      = IDX_W'(rd_off >> BYTE_BITS);
    wr_idx      = IDX_W'(wr_off >> BYTE_BITS);
  end

  // Handshake and backpressure
  always_comb begin
    lfsr_fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    stall_rd       = stall_en && (lfsr[1:0] == 2'b00);
    stall_wr       = stall_en && (lfsr[3:2] == 2'b00);
    rd_waitrequest = !rst_n || stall_rd || (pending_cnt >= PEND_LIMIT);
    wr_waitrequest = !rst_n || stall_wr;
    rd_accept      = rd_read && !rd_waitrequest;
    wr_accept      = wr_write && !wr_waitrequest;
    rd_retire      = vld_pipe[READ_LATENCY-1];
    err_inc        = 2'(rd_accept && !rd_in_range) + 2'(wr_accept && !wr_in_range);
    err_sum        = 17'(err_cnt) + 17'(err_inc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Pending counter and error counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      case ({rd_accept, rd_retire})
        2'b10:   pending_cnt <= pending_cnt + 4'd1;
        2'b01:   pending_cnt <= pending_cnt - 4'd1;
        default: pending_cnt <= pending_cnt;
      endcase
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  // Valid/error shift pipeline and registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe         <= '0;
      err_pipe         <= '0;
      rd_readdatavalid <= 1'b0;
      rd_readdata      <= '0;
    end else begin
      vld_pipe[0] <= rd_accept;
      err_pipe[0] <= rd_accept && !rd_in_range;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
      end
      rd_readdatavalid <= rd_retire;
      rd_readdata      <= (rd_retire && !err_pipe[READ_LATENCY-1]) ? dat_pipe[READ_LATENCY-1] : '0;
    end
  end

  // Data pipeline needs no reset: it is gated by the valid/error pipe on the way out.
  always_ff @(posedge clk) begin
    dat_pipe[0] <= mem[rd_idx];
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      dat_pipe[i] <= dat_pipe[i-1];
    end
  end

  // Nonblocking write gives read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (wr_accept && wr_in_range) begin
      mem[wr_idx] <= wr_writedata;
    end
  end

endmodule

// File: tb/tb_netdma_mm_ram_slave.sv
// Self-checking bench for netdma_mm_ram_slave: directed vectors plus a negedge scoreboard.
// A second instance runs with READ_LATENCY=4, MAX_PENDING=2 for the pending-limit case.
module tb_netdma_mm_ram_slave;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [32:0] SPAN = 33'h2000;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_en;
  logic [31:0] rd_address, wr_address;
  logic        rd_read, wr_write;
  logic [63:0] wr_writedata, rd_readdata;
  logic        rd_readdatavalid, rd_waitrequest, wr_waitrequest;
  logic [15:0] err_cnt;

  logic        stall_en2;
  logic [31:0] rd_address2, wr_address2;
  logic        rd_read2, wr_write2;
  logic [63:0] wr_writedata2, rd_readdata2;
  logic        rd_readdatavalid2, rd_waitrequest2, wr_waitrequest2;
  logic [15:0] err_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int n_val   = 0;
  int n_val2  = 0;
  int max_inflight2 = 0;
  exp_t        exp_q[$];
  logic [63:0] seen_q[$];
  logic [63:0] exp2_q[$];
  logic [63:0] mem_m [1024];

  always #5 clk = ~clk;

  netdma_mm_ram_slave u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_en         (stall_en),
    .rd_address       (rd_address),
    .rd_read          (rd_read),
    .rd_readdata      (rd_readdata),
    .rd_readdatavalid (rd_readdatavalid),
    .rd_waitrequest   (rd_waitrequest),
    .wr_address       (wr_address),
    .wr_write         (wr_write),
    .wr_writedata     (wr_writedata),
    .wr_waitrequest   (wr_waitrequest),
    .err_cnt          (err_cnt)
  );

  netdma_mm_ram_slave #(.READ_LATENCY(4), .MAX_PENDING(2)) u_dut_pend (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_en         (stall_en2),
    .rd_address       (rd_address2),
    .rd_read          (rd_read2),
    .rd_readdata      (rd_readdata2),
    .rd_readdatavalid (rd_readdatavalid2),
    .rd_waitrequest   (rd_waitrequest2),
    .wr_address       (wr_address2),
    .wr_write         (wr_write2),
    .wr_writedata     (wr_writedata2),
    .wr_waitrequest   (wr_waitrequest2),
    .err_cnt          (err_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard for the default instance: responses first, then accepts (read before write).
  always @(negedge clk) begin
    logic [32:0] off;
    exp_t        e;
    if (rd_readdatavalid) begin
      n_val++;
      if (exp_q.size() == 0) begin
        check("stray_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_readdata, e.data);
        check("rd_latency", 64'(cyc - e.cyc), 64'd2);
        seen_q.push_back(rd_readdata);
      end
    end else begin
      check("rd_data_idle", rd_readdata, 64'd0);
    end
    if (!rst_n) exp_q.delete();
    if (rd_read && !rd_waitrequest) begin
      n_acc++;
      off = 33'(rd_address) - 33'(BASE);
      e.cyc  = cyc + 1;
      e.data = (!off[32] && off < SPAN) ? mem_m[off[12:3]] : 64'd0;
      exp_q.push_back(e);
    end
    if (wr_write && !wr_waitrequest) begin
      off = 33'(wr_address) - 33'(BASE);
      if (!off[32] && off < SPAN) mem_m[off[12:3]] = wr_writedata;
    end
  end

  // Scoreboard for the pending-limit instance; word i holds 0x200+i.
  always @(negedge clk) begin
    if (rd_readdatavalid2) begin
      n_val2++;
      if (exp2_q.size() == 0) check("p2_stray_valid", 64'd1, 64'd0);
      else check("p2_data", rd_readdata2, exp2_q.pop_front());
    end
    if (rd_read2 && !rd_waitrequest2) exp2_q.push_back(64'h200 + 64'(rd_address2 >> 3));
    if (exp2_q.size() > max_inflight2) max_inflight2 = exp2_q.size();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, snap, n_rdw, n_wrw;
    logic rd_go, wr_go, go;

    rst_n = 1'b0; stall_en = 1'b0; stall_en2 = 1'b0;
    rd_read = 1'b0; wr_write = 1'b0; rd_address = '0; wr_address = '0; wr_writedata = '0;
    rd_read2 = 1'b0; wr_write2 = 1'b0; rd_address2 = '0; wr_address2 = '0; wr_writedata2 = '0;

    // Reset
    repeat (3) begin
      tick();
      check("rst_rd_wait", 64'(rd_waitrequest), 64'd1);
      check("rst_wr_wait", 64'(wr_waitrequest), 64'd1);
      check("rst_valid", 64'(rd_readdatavalid), 64'd0);
    end
    rst_n = 1'b1;
    tick();
    check("rel_rd_wait", 64'(rd_waitrequest), 64'd0);
    check("rel_wr_wait", 64'(wr_waitrequest), 64'd0);
    check("rel_err_cnt", 64'(err_cnt), 64'd0);

    // Streaming writes then 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      wr_write = 1'b1; wr_address = BASE + 32'(8 * i); wr_writedata = 64'h100 + 64'(i);
      #1 check("stream_wr_wait", 64'(wr_waitrequest), 64'd0);
      tick();
    end
    wr_write = 1'b0;
    seen_q.delete();
    for (int i = 0; i < 16; i++) begin
      rd_read = 1'b1; rd_address = BASE + 32'(8 * i);
      #1 check("stream_rd_wait", 64'(rd_waitrequest), 64'd0);
      tick();
    end
    rd_read = 1'b0;
    drain(20);
    check("stream_count", 64'(seen_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) check("stream_data", seen_q[i], 64'h100 + 64'(i));
    check("stream_err_cnt", 64'(err_cnt), 64'd0);

    // Same-word collision: read-before-write, then new data
    wr_write = 1'b1; wr_address = BASE + 32'd40; wr_writedata = 64'hAAAA;
    tick();
    wr_writedata = 64'h5555; rd_read = 1'b1; rd_address = BASE + 32'd40;
    tick();
    wr_write = 1'b0;
    seen_q.delete();
    tick();
    rd_read = 1'b0;
    drain(10);
    check("coll_old", seen_q[0], 64'hAAAA);
    check("coll_new", seen_q[1], 64'h5555);

    // Out-of-range read and write in the same cycle, then saturation
    rd_read = 1'b1; rd_address = BASE + 32'h2000;
    wr_write = 1'b1; wr_address = BASE - 32'd8; wr_writedata = 64'hDEAD;
    seen_q.delete();
    tick();
    check("oor_err_cnt_2", 64'(err_cnt), 64'd2);
    repeat (35000) tick();
    rd_read = 1'b0; wr_write = 1'b0;
    drain(10);
    check("oor_rd_zero", seen_q[0], 64'd0);
    check("oor_err_sat", 64'(err_cnt), 64'hFFFF);

    // Pending limit on the READ_LATENCY=4, MAX_PENDING=2 instance
    for (int i = 0; i < 10; i++) begin
      wr_write2 = 1'b1; wr_address2 = 32'(8 * i); wr_writedata2 = 64'h200 + 64'(i);
      tick();
    end
    wr_write2 = 1'b0;
    rd_read2 = 1'b1; rd_address2 = '0; k = 0;
    for (int c = 0; c < 200 && k < 10; c++) begin
      @(negedge clk);
      go = rd_read2 && !rd_waitrequest2;
      tick();
      if (go) begin
        k++;
        if (k == 2) check("p2_wait_after_2", 64'(rd_waitrequest2), 64'd1);
        if (k < 10) rd_address2 = 32'(8 * k);
        else rd_read2 = 1'b0;
      end
    end
    check("p2_accepts", 64'(k), 64'd10);
    for (int c = 0; c < 40 && n_val2 < 10; c++) tick();
    check("p2_valids", 64'(n_val2), 64'd10);
    check("p2_max_inflight", 64'(max_inflight2), 64'd2);

    // Stall injection with random traffic; masters hold requests under waitrequest
    stall_en = 1'b1; n_rdw = 0; n_wrw = 0; snap = n_acc;
    n_val = 0; n_acc = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      rd_go = rd_read && !rd_waitrequest;
      wr_go = wr_write && !wr_waitrequest;
      if (c < 1000 && rd_waitrequest) n_rdw++;
      if (c < 1000 && wr_waitrequest) n_wrw++;
      tick();
      if (!rd_read || rd_go) begin
        rd_read = (c < 1000) && ($urandom_range(1, 0) == 1);
        rd_address = ($urandom_range(15, 0) == 0) ? 32'h4000 : BASE + 32'($urandom_range(15, 0)) * 32'd8;
      end
      if (!wr_write || wr_go) begin
        wr_write = (c < 1000) && ($urandom_range(1, 0) == 1);
        wr_address = BASE + 32'($urandom_range(15, 0)) * 32'd8;
        wr_writedata = {$urandom(), $urandom()};
      end
    end
    check("stall_req_done", 64'({rd_read, wr_write}), 64'd0);
    drain(20);
    check("stall_no_loss", 64'(n_val), 64'(n_acc));
    check("stall_rd_ratio", 64'(n_rdw > 150 && n_rdw < 350), 64'd1);
    check("stall_wr_ratio", 64'(n_wrw > 150 && n_wrw < 350), 64'd1);

    // Reset asserted with two reads in flight
    stall_en = 1'b0;
    rd_read = 1'b1; rd_address = BASE;
    tick();
    rd_address = BASE + 32'd8;
    tick();
    rst_n = 1'b0; rd_read = 1'b0;
    snap = n_val;
    repeat (3) begin
      tick();
      check("mid_rst_valid", 64'(rd_readdatavalid), 64'd0);
      check("mid_rst_rd_wait", 64'(rd_waitrequest), 64'd1);
    end
    rst_n = 1'b1;
    repeat (10) tick();
    check("mid_rst_no_stray", 64'(n_val - snap), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
